shift_lr_register: RTL and testbench



---
 rtl/shift_lr_register.sv | 68 ++++++
 tb/tb_shift_lr_register.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/shift_lr_register.sv
// Bidirectional serial-in / parallel-out shift register with synchronous
// parallel load and hold. Left shifts move data toward the MSB with the
// serial bit entering at bit 0; right shifts move data toward the LSB with
// the serial bit entering at the MSB. The serial output presents the bit
// that would leave the register on the next shift in the selected direction.

module shift_lr_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] pi,
    input  logic             si,
    input  logic             left_right,
    output logic [WIDTH-1:0] po,
    output logic             so
);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] next_s;
    logic             so_s;

    // Next-state selection: parallel load wins over shifting, shifting over hold.
    always_comb begin
        next_s = shreg_r;
        if (load) begin
            next_s = pi;
        end else if (en) begin
            case (left_right)
                DIR_LEFT:  next_s = {shreg_r[WIDTH-2:0], si};
                DIR_RIGHT: next_s = {si, shreg_r[WIDTH-1:1]};
                default:   next_s = shreg_r;
            endcase
        end else begin
            next_s = shreg_r;
        end
    end

    // Register state; reset discards contents immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= RESET_VALUE;
        end else begin
            shreg_r <= next_s;
        end
    end

    // Outgoing bit follows the direction select with no extra register stage,
    // so a direction change is visible on so before the next edge.
    always_comb begin
        so_s = shreg_r[WIDTH-1];
        case (left_right)
            DIR_LEFT:  so_s = shreg_r[WIDTH-1];
            DIR_RIGHT: so_s = shreg_r[0];
            default:   so_s = shreg_r[WIDTH-1];
        endcase
    end

    assign po = shreg_r;
    assign so = so_s;

endmodule

// File: tb/tb_shift_lr_register.sv
// Scoreboard bench for shift_lr_register (WIDTH=8, RESET_VALUE=0).
// The driver pushes the expected po/so for every clock edge it issues (and
// for immediate checks between edges); the monitor pops and compares one
// entry after each rising edge or on an explicit sample request.

module tb_shift_lr_register;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] pi;
    logic       si;
    logic       left_right;
    logic [7:0] po;
    logic       so;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_po_q [$];
    logic       exp_so_q [$];
    string      name_q   [$];

    event chk_ev;

    shift_lr_register #(
        .WIDTH      (8),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .pi        (pi),
        .si        (si),
        .left_right(left_right),
        .po        (po),
        .so        (so)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry is consumed per rising edge or sample request.
    initial begin
        logic [7:0] ep;
        logic       es;
        string      nm;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_po_q.size() > 0) begin
                ep = exp_po_q.pop_front();
                es = exp_so_q.pop_front();
                nm = name_q.pop_front();
                compared++;
                if (po !== ep) begin
                    mismatched++;
                    $display("FAIL %s po: got %02h expected %02h", nm, po, ep);
                end
                compared++;
                if (so !== es) begin
                    mismatched++;
                    $display("FAIL %s so: got %b expected %b", nm, so, es);
                end
            end
        end
    end

    // Push an expectation; so is the outgoing bit of exp in direction dir.
    task automatic push_exp(input logic [7:0] exp, input logic dir, input string nm);
        exp_po_q.push_back(exp);
        exp_so_q.push_back(dir ? exp[0] : exp[7]);
        name_q.push_back(nm);
    endtask

    // One clock edge with the given controls; inputs return to idle afterwards.
    task automatic step(input logic ld, input logic e, input logic dir,
                        input logic s, input logic [7:0] p,
                        input logic [7:0] exp, input string nm);
        @(negedge clk);
        load       = ld;
        en         = e;
        left_right = dir;
        si         = s;
        pi         = p;
        push_exp(exp, dir, nm);
        @(posedge clk);
        #2;
        load = 1'b0;
        en   = 1'b0;
    endtask

    // Immediate check between edges (async reset, combinational so).
    task automatic check_now(input logic [7:0] exp, input string nm);
        push_exp(exp, left_right, nm);
        -> chk_ev;
        #2;
    endtask

    logic [7:0] fill_l [8];
    logic       bits_l [8];
    logic [7:0] flush_l [4];
    logic [7:0] fill_r [8];

    initial begin
        fill_l  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2D, 8'h5A, 8'hB5};
        bits_l  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        flush_l = '{8'h6A, 8'hD4, 8'hA8, 8'h50};
        fill_r  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        rst_n = 1'b0; en = 1'b0; load = 1'b0; pi = 8'h00; si = 1'b0; left_right = 1'b0;
        #2;
        check_now(8'h00, "reset_initial");
        rst_n = 1'b1;

        // Reset: load FF, then assert reset asynchronously and hold across an edge.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, "preload_ff");
        rst_n = 1'b0;
        check_now(8'h00, "async_reset");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, "reset_held");
        rst_n = 1'b1;

        // Left shift fill.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b0, bits_l[i], 8'h00, fill_l[i], "left_fill");

        // Left shift flush with zeros.
        check_now(8'hB5, "flush_so_pre");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, flush_l[i], "left_flush");

        // Right shift four, then back left four.
        left_right = 1'b1;
        check_now(8'h50, "dir_change_so");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h28, "right_shift");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h14, "right_shift");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h0A, "right_shift");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05, "right_shift");
        left_right = 1'b0;
        check_now(8'h05, "dir_back_so");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h0A, "left_again");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h14, "left_again");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h28, "left_again");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h50, "left_again");

        // Hold with en=0, then load has priority over shift.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h50, "hold");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h3C, "load_priority");
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3, "load_ignores_dir");

        // Right fill with ones; reset mid-sequence, then a full refill.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "load_zero");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, fill_r[i], "right_fill_part");
        rst_n = 1'b0;
        check_now(8'h00, "mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, fill_r[i], "right_fill");

        // Let the monitor drain; any leftover expectation is a failure.
        repeat (3) @(posedge clk);
        #3;
        compared++;
        if (exp_po_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_po_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
